// File: rtl/axis_stream_receiver_if.sv
// AXI4-Stream bus between the DMA MM2S channel and the stream receiver.
interface axis_stream_receiver_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_stream_receiver.sv
// Receive end of the DMA MM2S path: accepts one fixed-length packet, checks
// tlast against the programmed beat count and buffers the beats in a small
// first-word-fall-through FIFO toward PL logic.
module axis_stream_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [25:0]           count,
  axis_stream_receiver_if.slave s_axis,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err_early_last,
  output logic                  err_late_last,
  output logic [25:0]           rx_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state;
  logic [25:0] count_reg;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           fill;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  last_beat;
  logic                  drain_ends;

  // FIFO status from the extra pointer MSB: equal pointers are empty,
  // MSB-differing pointers with equal index bits are full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill  = wr_ptr - rd_ptr;

  // tready depends only on registered state and fill level, never on tvalid.
  assign s_axis.tready = ((state == RECV) && !full) || (state == FLUSH);

  assign accept    = s_axis.tvalid && s_axis.tready;
  assign push      = accept && (state == RECV);
  assign pop       = !empty && ready_in;
  assign last_beat = (rx_count == (count_reg - 26'd1));

  // The drain finishes at the edge where the FIFO is, or is about to become,
  // empty; done and IDLE land together so a back-to-back start is accepted.
  assign drain_ends = empty || (pop && (fill == {{AW{1'b0}}, 1'b1}));

  assign valid_out = !empty;
  assign data_out  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign busy      = (state != IDLE);

  // Buffer storage: data only, needs no reset since empty masks data_out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s_axis.tdata;
    end
  end

  // FIFO pointer update on push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Packet FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      count_reg      <= '0;
      rx_count       <= '0;
      err_early_last <= 1'b0;
      err_late_last  <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (count != 26'd0)) begin
            count_reg      <= count;
            rx_count       <= '0;
            err_early_last <= 1'b0;
            err_late_last  <= 1'b0;
            state          <= RECV;
          end
        end
        RECV: begin
          if (push) begin
            rx_count <= rx_count + 26'd1;
            if (last_beat) begin
              if (s_axis.tlast) begin
                state <= DRAIN;
              end else begin
                err_late_last <= 1'b1;
                state         <= FLUSH;
              end
            end else if (s_axis.tlast) begin
              err_early_last <= 1'b1;
              state          <= DRAIN;
            end
          end
        end
        FLUSH: begin
          if (accept && s_axis.tlast) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_ends) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stream_receiver.sv
// Directed bench for axis_stream_receiver (DATA_WIDTH=32, FIFO_DEPTH=4).
module tb_axis_stream_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [25:0] count;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        busy;
  logic        done;
  logic        err_early_last;
  logic        err_late_last;
  logic [25:0] rx_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] got[$];
  int          done_cnt;

  axis_stream_receiver_if #(.DATA_WIDTH(32)) s_axis ();

  axis_stream_receiver #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .count          (count),
    .s_axis         (s_axis),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .busy           (busy),
    .done           (done),
    .err_early_last (err_early_last),
    .err_late_last  (err_late_last),
    .rx_count       (rx_count)
  );

  always #5 clk = ~clk;

  // Record every popped word and every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid_out && ready_in) got.push_back(data_out);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [25:0] c);
    start = 1'b1;
    count = c;
    tick();
    start = 1'b0;
  endtask

  // Present one beat and hold it until the edge where it is accepted.
  task automatic send_beat(input string tag, input logic [31:0] d, input logic last);
    int k;
    s_axis.tdata  = d;
    s_axis.tlast  = last;
    s_axis.tvalid = 1'b1;
    k = 0;
    while (!s_axis.tready && k < 100) begin
      tick();
      k++;
    end
    check({tag, "_rdy"}, s_axis.tready, 1);
    tick();
  endtask

  task automatic idle_bus();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_idle_at_done"}, busy, 0);
  endtask

  task automatic check_words(input string tag, input logic [31:0] base, input int n);
    check({tag, "_nwords"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check({tag, "_word"}, got[i], base + i);
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    count         = '0;
    ready_in      = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    done_cnt      = 0;
    tick();
    tick();

    // Reset state
    check("rst_tready", s_axis.tready, 0);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_errs", {err_early_last, err_late_last}, 0);
    check("rst_rxcnt", rx_count, 0);
    check("rst_data", data_out, 0);
    rst = 1'b0;
    tick();

    // Normal packet: 4 beats back-to-back, one cycle data latency
    got.delete();
    done_cnt = 0;
    ready_in = 1'b1;
    do_start(26'd4);
    check("t1_busy", busy, 1);
    check("t1_tready", s_axis.tready, 1);
    for (int i = 0; i < 4; i++) begin
      s_axis.tdata  = 32'hA0 + i;
      s_axis.tlast  = (i == 3);
      s_axis.tvalid = 1'b1;
      tick();
      check("t1_valid", valid_out, 1);
      check("t1_data", data_out, 32'hA0 + i);
    end
    idle_bus();
    check("t1_tready_drain", s_axis.tready, 0);
    tick();
    check("t1_done", done, 1);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_rxcnt", rx_count, 4);
    check("t1_errs", {err_early_last, err_late_last}, 0);
    check("t1_ndone", done_cnt, 1);
    check_words("t1", 32'hA0, 4);

    // Backpressure: count=8 with ready_in low fills the 4-entry FIFO
    got.delete();
    done_cnt = 0;
    ready_in = 1'b0;
    do_start(26'd8);
    for (int i = 0; i < 4; i++) send_beat("t2_fill", 32'hB0 + i, 1'b0);
    check("t2_full_tready", s_axis.tready, 0);
    check("t2_rxcnt4", rx_count, 4);
    check("t2_head", data_out, 32'hB0);
    s_axis.tdata  = 32'hB4;
    s_axis.tvalid = 1'b1;
    tick();
    tick();
    check("t2_stall_tready", s_axis.tready, 0);
    check("t2_stall_rxcnt", rx_count, 4);
    ready_in = 1'b1;
    for (int i = 4; i < 8; i++) send_beat("t2_rest", 32'hB0 + i, i == 7);
    idle_bus();
    wait_done("t2");
    tick();
    check("t2_rxcnt", rx_count, 8);
    check("t2_ndone", done_cnt, 1);
    check_words("t2", 32'hB0, 8);

    // Early tlast on the 3rd beat of an 8-beat packet
    got.delete();
    done_cnt = 0;
    do_start(26'd8);
    for (int i = 0; i < 3; i++) send_beat("t3", 32'hC0 + i, i == 2);
    idle_bus();
    check("t3_early", err_early_last, 1);
    check("t3_late", err_late_last, 0);
    check("t3_rxcnt", rx_count, 3);
    check("t3_tready", s_axis.tready, 0);
    wait_done("t3");
    tick();
    check("t3_early_sticky", err_early_last, 1);
    check_words("t3", 32'hC0, 3);

    // Late tlast: 6 beats for count=4, beats 5-6 discarded
    got.delete();
    done_cnt = 0;
    do_start(26'd4);
    check("t4_err_cleared", err_early_last, 0);
    for (int i = 0; i < 4; i++) send_beat("t4", 32'hD0 + i, 1'b0);
    check("t4_late", err_late_last, 1);
    check("t4_flush_tready", s_axis.tready, 1);
    send_beat("t4_flush", 32'hD4, 1'b0);
    send_beat("t4_flush", 32'hD5, 1'b1);
    idle_bus();
    check("t4_rxcnt_flush", rx_count, 4);
    wait_done("t4");
    tick();
    check("t4_rxcnt", rx_count, 4);
    check("t4_early", err_early_last, 0);
    check_words("t4", 32'hD0, 4);

    // Start filtering: count=0 ignored, start while busy ignored
    do_start(26'd0);
    check("t5_zero_busy", busy, 0);
    check("t5_zero_tready", s_axis.tready, 0);
    got.delete();
    done_cnt = 0;
    do_start(26'd3);
    check("t5_late_cleared", err_late_last, 0);
    send_beat("t5", 32'hE0, 1'b0);
    idle_bus();
    do_start(26'd8);
    send_beat("t5", 32'hE1, 1'b0);
    send_beat("t5", 32'hE2, 1'b1);
    idle_bus();
    wait_done("t5");
    check("t5_errs", {err_early_last, err_late_last}, 0);
    check("t5_rxcnt", rx_count, 3);
    tick();
    check_words("t5", 32'hE0, 3);

    // Asynchronous reset mid-packet with two words buffered
    ready_in = 1'b0;
    do_start(26'd8);
    send_beat("t6", 32'hF0, 1'b0);
    send_beat("t6", 32'hF1, 1'b0);
    idle_bus();
    check("t6_pre_valid", valid_out, 1);
    check("t6_pre_rxcnt", rx_count, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_tready", s_axis.tready, 0);
    check("t6_rst_valid", valid_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_data", data_out, 0);
    check("t6_rst_rxcnt", rx_count, 0);
    rst = 1'b0;
    tick();
    got.delete();
    done_cnt = 0;
    ready_in = 1'b1;
    do_start(26'd2);
    send_beat("t6_new", 32'h50, 1'b0);
    send_beat("t6_new", 32'h51, 1'b1);
    idle_bus();
    wait_done("t6");
    tick();
    check("t6_errs", {err_early_last, err_late_last}, 0);
    check("t6_rxcnt", rx_count, 2);
    check_words("t6", 32'h50, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
